// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and the
// odd-parity helper that both the receiver and a future transmitter use.
package ps2_pkg;

  localparam int FRAME_BITS    = 11;
  localparam int PS2_DATA_BITS = FRAME_BITS - 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample glitch filter for an
// asynchronous PS/2 line; outputs the filtered level and a one-cycle fall pulse.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_level;
  logic                  r_level_d;

  // The level only moves once the whole history agrees; anything shorter holds.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync    <= 2'b11;
      r_hist    <= '1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_line};
      r_hist    <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
      r_level_d <= r_level;
      if (&r_hist) begin
        r_level <= 1'b1;
      end else if (~|r_hist) begin
        r_level <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_level_d & ~r_level;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: deserialises 11-bit frames and emits a
// one-cycle valid, parity-error or frame-error strobe per completed frame.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     ps2_clk_i,
  input  logic                     ps2_data_i,
  output logic [PS2_DATA_BITS-1:0] data_o,
  output logic                     valid_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(PS2_DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_next_state;

  logic [1:0]               r_data_sync;
  logic [CW-1:0]            r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic [TW-1:0]            r_tmo;

  logic w_clk_level;
  logic w_clk_fall;
  logic w_fall;
  logic w_data;
  logic w_timeout;
  logic w_valid_nxt;
  logic w_perr_nxt;
  logic w_ferr_nxt;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .i_line  (ps2_clk_i),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  assign w_fall    = w_clk_fall & ~w_clk_level;
  assign w_data    = r_data_sync[1];
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tmo == TMO_LAST);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_data) w_next_state = DATA;
        DATA:    if (r_bit_cnt == LAST_BIT) w_next_state = PARITY;
        PARITY:  w_next_state = STOP;
        STOP:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
    if (w_timeout) begin
      w_next_state = IDLE;
    end
  end

  // A bad stop bit outranks a parity fault, so only one strobe ever fires.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = w_timeout;
    if (w_fall && (r_state == STOP)) begin
      if (!w_data) begin
        w_ferr_nxt = 1'b1;
      end else if (r_parity != odd_parity(r_shift)) begin
        w_perr_nxt = 1'b1;
      end else begin
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data_sync  <= 2'b11;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tmo        <= '0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      r_data_sync  <= {r_data_sync[0], ps2_data_i};
      valid_o      <= w_valid_nxt;
      parity_err_o <= w_perr_nxt;
      frame_err_o  <= w_ferr_nxt;
      if (w_valid_nxt) begin
        data_o <= r_shift;
      end
      if (w_fall) begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY:  r_parity <= w_data;
          default: ;
        endcase
      end
      if ((r_state == IDLE) || w_fall || w_timeout) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host byte receiver that sits directly upstream of the mouse packet decoder. It synchronises and deglitches the raw PS/2 clock and data lines and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good byte is presented to the mouse decoder as a single-cycle strobe, which that block assembles into x/y/button packets. Parity, framing and timeout faults are flagged and dropped.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered clock changes (≥2).
TIMEOUT_CYCLES, 20000, clk_i cycles without a filtered falling edge before a partial frame is aborted (200 µs at 100 MHz).

Ports:
clk_i  input  1  system clock, 100 MHz.
reset_ni  input  1  asynchronous active-low reset.
ps2_clk_i  input  1  raw PS/2 clock line, asynchronous.
ps2_data_i  input  1  raw PS/2 data line, asynchronous.
data_o  output  8  last correctly received byte; held between strobes.
valid_o  output  1  one-cycle strobe: data_o updated this cycle.
parity_err_o  output  1  one-cycle strobe: frame had bad parity.
frame_err_o  output  1  one-cycle strobe: bad start/stop bit or timeout.

Behaviour:
- Reset (async assert, sync release): data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, FSM=IDLE, filtered clk=1, sync flops=1, bit count=0, timeout counter=0.
- Sync: 2-flop synchroniser on each of ps2_clk_i and ps2_data_i.
- Filter: FILTER_LEN-deep shift of synced clk. Filtered clk goes to 1 when all ones and to 0 when all zeros, otherwise it holds. Pulses shorter than FILTER_LEN cycles are ignored.
- Fall event: filtered clk registered 1 → current 0. The FSM acts on the synced data value in that cycle.
- FSM states and transitions:
  - IDLE: on fall with data=0, go to DATA and set bit count=0. On fall with data=1, stay in IDLE with no flag.
  - DATA: on fall, shift the data bit into the shift register MSB and shift right, so the byte lands LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, return to IDLE and assert exactly one strobe on the next clock edge:
    - stop bit = 0 → frame_err_o. This takes priority over a parity error.
    - otherwise, XOR of the 8 data bits and the parity bit = 0 → parity_err_o.
    - otherwise → valid_o, with data_o loaded in the same cycle.
- Latency: valid_o rises exactly FILTER_LEN+4 clk_i cycles after the raw ps2_clk_i stop-bit falling edge, given clean lines.
- Timeout:
  - The counter clears on every fall event and while in IDLE.
  - In any other state it increments. When it reaches TIMEOUT_CYCLES-1: frame_err_o pulses, the FSM goes to IDLE and the counter clears.
- Strobes are mutually exclusive and never wider than one cycle.
- data_o changes only on valid_o; errors leave it unchanged.
- Reset mid-frame discards the partial frame. The next fall with data=0 starts a fresh frame.
- Rising edges of the filtered clock are ignored.

Decomposition:
- Package ps2_pkg holds:
  - the state enum rx_state_t (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_BITS=8;
  - the FRAME_BITS=11 constant;
  - an odd-parity function shared with a future ps2_tx.
- One sub-module, ps2_sync_filter: 2-flop synchroniser plus FILTER_LEN glitch filter, with the filtered level and a fall pulse as outputs. It is instantiated for the clock line. The data line uses a plain 2-flop sync.

Test Plan:
- Frame 0xA5, parity bit 1, stop bit 1, ~12.5 kHz PS/2 clock → valid_o high exactly 1 cycle, FILTER_LEN+4 cycles after the last falling edge; data_o=0xA5; no error strobes.
- Frame 0x08 sent with parity bit 1 (wrong) → parity_err_o pulses once; valid_o stays 0; data_o keeps its prior value 0xA5.
- Frame 0x3C, correct parity, stop bit 0 → frame_err_o pulses once, parity_err_o stays 0. A following good frame 0x3C → valid_o with data_o=0x3C.
- Start bit plus 4 data bits, then ps2_clk_i held high → frame_err_o pulses TIMEOUT_CYCLES-1 cycles after the last fall event. A next full frame 0xF4 is received correctly.
- Idle line, 3-cycle and 7-cycle low glitches on ps2_clk_i (FILTER_LEN=8) → no state change and no strobes. A subsequent frame 0xFA is received correctly.
- reset_ni pulsed low after 5 bits of a frame → all outputs 0 immediately. A next full frame 0x55 → valid_o with data_o=0x55.
